// File: rtl/instruction_fetch_sequencer.sv
// instruction_fetch_sequencer: IDLE/REQ/HOLD fetch FSM between PC, I-mem and decode.
// Define FETCH_TIMEOUT_EN to add a request timeout with a sticky ERR state.
module instruction_fetch_sequencer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCResult,
    output logic [31:0] Address,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic        MemAck,
    input  logic [31:0] MemData,
    output logic [31:0] Instr,
    output logic        InstrValid,
    input  logic        InstrReady,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic        FetchErr
);

`ifdef FETCH_TIMEOUT_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;
`endif

    state_t state;
    state_t state_nxt;
    logic   capture;
    logic   timeout_hit;

    // A memory response is only taken while a request is outstanding and
    // no redirect is squashing the fetch.
    assign capture = (state == REQ) && MemAck && !Redirect;

    // The read address always tracks the held PC.
    assign MemAddr = PCResult;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Count REQ cycles without MemAck; cleared on every entry into REQ.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wait_cnt <= '0;
        end else if ((state_nxt == REQ) && ((state != REQ) || Redirect)) begin
            wait_cnt <= '0;
        end else if ((state == REQ) && !MemAck) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = (state == REQ) && !MemAck &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
`endif

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a redirect overrides everything and restarts fetch.
    always_comb begin
        state_nxt = state;
        if (Redirect) begin
            state_nxt = REQ;
        end else begin
            case (state)
                IDLE: state_nxt = REQ;
                REQ: begin
                    if (MemAck) begin
                        state_nxt = HOLD;
                    end else if (timeout_hit) begin
`ifdef FETCH_TIMEOUT_EN
                        state_nxt = ERR;
`else
                        state_nxt = REQ;
`endif
                    end
                end
                HOLD: begin
                    if (InstrReady) begin
                        state_nxt = REQ;
                    end
                end
`ifdef FETCH_TIMEOUT_EN
                ERR: state_nxt = ERR;
`endif
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output decode; the PC advances only on a completed decode handshake.
    always_comb begin
        MemReq     = 1'b0;
        InstrValid = 1'b0;
        FetchErr   = 1'b0;
        Address    = PCResult;
        case (state)
            REQ: MemReq = 1'b1;
            HOLD: begin
                InstrValid = !Redirect;
                if (InstrReady) begin
                    Address = PCResult + 32'd4;
                end
            end
`ifdef FETCH_TIMEOUT_EN
            ERR: FetchErr = 1'b1;
`endif
            default: begin
            end
        endcase
        if (Redirect) begin
            Address = RedirectTarget;
        end
        if (!Reset) begin
            MemReq     = 1'b0;
            InstrValid = 1'b0;
            FetchErr   = 1'b0;
            Address    = PCResult;
        end
    end

    // Instruction register, loaded only by an accepted memory response.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Instr <= 32'd0;
        end else if (capture) begin
            Instr <= MemData;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// tb_instruction_fetch_sequencer: bench for the fetch sequencer with a
// behavioural fetch model, a PC register loop and directed literal checks.
module tb_instruction_fetch_sequencer;

    localparam int TO = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] PCResult;
    logic [31:0] Address;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemAck = 1'b0;
    logic [31:0] MemData = 32'd0;
    logic [31:0] Instr;
    logic        InstrValid;
    logic        InstrReady = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectTarget = 32'd0;
    logic        FetchErr;

    logic [31:0] pc_reg = 32'h40;
    logic        pc_load = 1'b0;
    logic [31:0] pc_force = 32'd0;
    logic        chk_en = 1'b0;

    int n_tests = 0;
    int n_fail = 0;

    typedef enum {P_IDLE, P_WAIT, P_HOLD, P_ERR} phase_t;
    phase_t      ph = P_IDLE;
    logic [31:0] m_instr = 32'd0;
    int          m_wait = 0;

    instruction_fetch_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .PCResult(PCResult),
        .Address(Address),
        .MemReq(MemReq),
        .MemAddr(MemAddr),
        .MemAck(MemAck),
        .MemData(MemData),
        .Instr(Instr),
        .InstrValid(InstrValid),
        .InstrReady(InstrReady),
        .Redirect(Redirect),
        .RedirectTarget(RedirectTarget),
        .FetchErr(FetchErr)
    );

    always #5 Clk = ~Clk;

    // The program counter register loads Address every edge.
    assign PCResult = pc_reg;
    always @(posedge Clk) pc_reg <= pc_load ? pc_force : Address;

    task automatic chk32(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Fetch model: what phase the fetch is in and what was last fetched.
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ph = P_IDLE;
            m_instr = 32'd0;
            m_wait = 0;
        end else if (Redirect) begin
            ph = P_WAIT;
            m_wait = 0;
        end else if (ph == P_IDLE) begin
            ph = P_WAIT;
            m_wait = 0;
        end else if (ph == P_WAIT) begin
            if (MemAck) begin
                m_instr = MemData;
                ph = P_HOLD;
            end else begin
                m_wait++;
`ifdef FETCH_TIMEOUT_EN
                if (m_wait == TO) ph = P_ERR;
`endif
            end
        end else if (ph == P_HOLD) begin
            if (InstrReady) begin
                ph = P_WAIT;
                m_wait = 0;
            end
        end
    end

    // Compare every cycle, mid-cycle, against the model's expectations.
    always @(negedge Clk) begin
        if (chk_en) begin
            logic [31:0] e_addr;
            if (!Reset) e_addr = PCResult;
            else if (Redirect) e_addr = RedirectTarget;
            else if (ph == P_HOLD && InstrReady) e_addr = PCResult + 32'd4;
            else e_addr = PCResult;
            chk1("m_memreq", MemReq, Reset && ph == P_WAIT);
            chk1("m_valid", InstrValid, Reset && ph == P_HOLD && !Redirect);
            chk1("m_fetcherr", FetchErr, Reset && ph == P_ERR);
            chk32("m_address", Address, e_addr);
            chk32("m_instr", Instr, m_instr);
            if (MemReq) chk32("m_memaddr", MemAddr, PCResult);
        end
    end

    initial begin
        #1 Reset = 1'b0;
        chk_en = 1'b1;
        step();
        step();
        #3;
        chk1("rst_memreq", MemReq, 1'b0);
        chk1("rst_valid", InstrValid, 1'b0);
        chk32("rst_instr", Instr, 32'd0);
        chk1("rst_err", FetchErr, 1'b0);
        chk32("rst_addr", Address, 32'h40);

        // Release with a stale MemAck that IDLE must ignore.
        step();
        Reset = 1'b1;
        MemAck = 1'b1;
        MemData = 32'hBAD0BAD0;
        #3;
        chk1("idle_memreq", MemReq, 1'b0);
        step();
        MemAck = 1'b0;
        #3;
        chk1("req_memreq", MemReq, 1'b1);
        chk32("req_memaddr", MemAddr, 32'h40);
        chk32("idle_noinstr", Instr, 32'd0);
        step();
        step();
        Reset = 1'b0;
        #1;
        chk1("midreq_rst_memreq", MemReq, 1'b0);
        chk32("midreq_rst_addr", Address, 32'h40);
        step();

        // Basic fetch at 0x00400000, ack on the third REQ cycle.
        pc_load = 1'b1;
        pc_force = 32'h00400000;
        step();
        pc_load = 1'b0;
        Reset = 1'b1;
        step();
        step();
        step();
        MemAck = 1'b1;
        MemData = 32'h8C080004;
        InstrReady = 1'b1;
        #3;
        chk32("ack_memaddr", MemAddr, 32'h00400000);
        chk32("ack_addr_held", Address, 32'h00400000);
        step();
        MemAck = 1'b0;
        #3;
        chk1("hold_valid", InstrValid, 1'b1);
        chk32("hold_instr", Instr, 32'h8C080004);
        chk32("hold_next_pc", Address, 32'h00400004);
        step();
        #3;
        chk1("valid_one_cycle", InstrValid, 1'b0);
        chk32("next_memaddr", MemAddr, 32'h00400004);

        // Decode stall for four cycles.
        step();
        MemAck = 1'b1;
        MemData = 32'h12345678;
        InstrReady = 1'b0;
        step();
        MemAck = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #3;
            chk1("stall_valid", InstrValid, 1'b1);
            chk32("stall_instr", Instr, 32'h12345678);
            chk32("stall_addr", Address, 32'h00400004);
            step();
        end
        InstrReady = 1'b1;
        #3;
        chk32("stall_release_addr", Address, 32'h00400008);
        step();
        InstrReady = 1'b0;

        // Redirect coincident with MemAck in REQ.
        Redirect = 1'b1;
        RedirectTarget = 32'h00000100;
        MemAck = 1'b1;
        MemData = 32'hDEADBEEF;
        #3;
        chk32("redir_instr_kept", Instr, 32'h12345678);
        chk1("redir_valid", InstrValid, 1'b0);
        chk32("redir_addr", Address, 32'h00000100);
        step();
        Redirect = 1'b0;
        MemAck = 1'b0;
        #3;
        chk1("redir_req", MemReq, 1'b1);
        chk32("redir_memaddr", MemAddr, 32'h00000100);
        chk32("redir_no_capture", Instr, 32'h12345678);

        // Redirect while holding an instruction.
        step();
        MemAck = 1'b1;
        MemData = 32'h0000A0A0;
        step();
        MemAck = 1'b0;
        Redirect = 1'b1;
        RedirectTarget = 32'h00000200;
        InstrReady = 1'b1;
        #3;
        chk1("hredir_valid", InstrValid, 1'b0);
        chk32("hredir_addr", Address, 32'h00000200);
        step();
        Redirect = 1'b0;
        InstrReady = 1'b0;
        #3;
        chk32("hredir_memaddr", MemAddr, 32'h00000200);
        chk32("hredir_instr", Instr, 32'h0000A0A0);

        // PC wrap at the top of the address space.
        pc_load = 1'b1;
        pc_force = 32'hFFFFFFFC;
        step();
        pc_load = 1'b0;
        MemAck = 1'b1;
        MemData = 32'h00000055;
        step();
        MemAck = 1'b0;
        InstrReady = 1'b1;
        #3;
        chk32("wrap_addr", Address, 32'h00000000);
        step();
        InstrReady = 1'b0;
        #3;
        chk32("wrap_memaddr", MemAddr, 32'h00000000);

`ifdef FETCH_TIMEOUT_EN
        Redirect = 1'b1;
        RedirectTarget = 32'h00000300;
        step();
        Redirect = 1'b0;
        for (int i = 0; i < TO; i++) begin
            #3;
            chk1("to_wait_err", FetchErr, 1'b0);
            chk1("to_wait_req", MemReq, 1'b1);
            step();
        end
        #3;
        chk1("to_err", FetchErr, 1'b1);
        chk1("to_err_memreq", MemReq, 1'b0);
        chk32("to_err_addr", Address, 32'h00000300);
        step();
        #3;
        chk1("to_err_sticky", FetchErr, 1'b1);
        Redirect = 1'b1;
        RedirectTarget = 32'h00000400;
        step();
        Redirect = 1'b0;
        #3;
        chk1("to_clear_err", FetchErr, 1'b0);
        chk1("to_clear_req", MemReq, 1'b1);
        chk32("to_clear_memaddr", MemAddr, 32'h00000400);
`endif

        // Mixed traffic checked by the model.
        for (int i = 0; i < 300; i++) begin
            step();
            MemAck = ($urandom_range(0, 2) == 0);
            MemData = $urandom;
            InstrReady = ($urandom_range(0, 1) == 1);
            Redirect = ($urandom_range(0, 9) == 0);
            RedirectTarget = $urandom & 32'hFFFFFFFC;
        end
        step();
        MemAck = 1'b0;
        Redirect = 1'b0;
        InstrReady = 1'b0;
        step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_sequencer.md
INSTRUCTION_FETCH_SEQUENCER -- requirements
Module: instruction_fetch_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum cycles a memory request may wait for MemAck before an error is flagged (used only with REQ-022).
REQ-002 Clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Reset  input  1  reset, asynchronous and active-low.
REQ-004 PCResult  input  32  current PC from the program counter register.
REQ-005 Address  output  32  next PC, loaded by the program counter on every rising edge.
REQ-006 MemReq  output  1  instruction memory read request.
REQ-007 MemAddr  output  32  instruction memory read address.
REQ-008 MemAck  input  1  memory read data valid, one-cycle pulse.
REQ-009 MemData  input  32  memory read data, qualified by MemAck.
REQ-010 Instr  output  32  fetched instruction to decode.
REQ-011 InstrValid  output  1  Instr is valid.
REQ-012 InstrReady  input  1  decode accepts Instr.
REQ-013 Redirect  input  1  branch/jump redirect request.
REQ-014 RedirectTarget  input  32  redirect destination address.
REQ-015 FetchErr  output  1  fetch timeout flag (REQ-022 only; otherwise tied 0).

Function
REQ-016 The FSM SHALL have states IDLE, REQ and HOLD, plus ERR when REQ-022 is compiled in.
- IDLE: MemReq=0, InstrValid=0; unconditionally go to REQ on the next edge.
REQ-017 REQ: MemReq=1, MemAddr=PCResult, Address=PCResult (PC held).
- MemAck=1: capture MemData into Instr; go to HOLD.
- Otherwise stay in REQ with MemReq held high.
REQ-018 HOLD: InstrValid=1, MemReq=0.
- InstrReady=0: Address=PCResult.
- InstrReady=1: Address=PCResult+4, modulo 2^32 (32'hFFFFFFFC wraps to 0); go to REQ. The handshake completes on that edge.
REQ-019 Redirect=1 in any state SHALL have the highest priority:
- Address=RedirectTarget.
- InstrValid=0 in that cycle.
- MemAck and InstrReady in the same cycle are ignored; no Instr capture.
- Next state is REQ.
REQ-020 Latency: MemAck at edge N SHALL produce InstrValid=1 from edge N; with InstrReady held high, back-to-back fetches take 2 cycles plus memory latency.
REQ-021 Instr SHALL hold its value while InstrValid=1 and change only on a MemAck capture.

Reset
REQ-023 Reset=0 SHALL asynchronously force:
- state=IDLE, MemReq=0, InstrValid=0, Instr=0, FetchErr=0;
- Address=PCResult (combinational hold).
REQ-024 Deassertion SHALL take effect at the next rising edge; a request in flight at reset is abandoned and a late MemAck is ignored in IDLE.

Configuration
REQ-022 Macro FETCH_TIMEOUT_EN:
- Defined: a counter clears on entry to REQ and increments each REQ cycle without MemAck. On reaching TIMEOUT_CYCLES the FSM goes to ERR:
  - MemReq=0, InstrValid=0, Address=PCResult;
  - FetchErr=1, sticky;
  - exits only via Redirect (to REQ, FetchErr cleared) or reset.
- Undefined: no counter and no ERR state; REQ waits indefinitely; FetchErr=0.

Verification
REQ-025 Reset=0 mid-REQ with PCResult=32'h00000040 -> MemReq=0 immediately, Address=32'h00000040; after release, IDLE for one cycle, then MemReq=1, MemAddr=32'h00000040.
REQ-026 PCResult=32'h00400000, MemAck after 3 cycles with MemData=32'h8C080004, InstrReady=1 -> Instr=32'h8C080004, InstrValid=1 for 1 cycle, Address=32'h00400004.
REQ-027 InstrReady=0 for 4 cycles in HOLD -> InstrValid and Instr stable, Address=PCResult throughout; then InstrReady=1 -> Address=PCResult+4.
REQ-028 Redirect=1, RedirectTarget=32'h00000100, coincident with MemAck -> Instr unchanged, InstrValid=0, Address=32'h00000100, next state REQ.
REQ-029 PCResult=32'hFFFFFFFC, completed handshake -> Address=32'h00000000.
REQ-030 With FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, no MemAck -> FetchErr=1 after 4 REQ cycles, MemReq=0; then Redirect -> FetchErr=0, MemReq=1.
